// File: rtl/zap_dmem_sequencer.sv
// Memory-stage data access sequencer: turns one load/store into a req/ack bus
// transfer with byte enables, stalling the pipeline until the word or a fault returns.
//
// state | meaning
// IDLE  | waiting for a load/store from the ALU stage
// BUSY  | bus request outstanding, timeout counter running
// DONE  | result/fault presented for one cycle, stall released
// DRAIN | flushed access still on the bus, result discarded
module zap_dmem_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic        i_mem_load,
    input  logic        i_mem_store,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wr_data,
    input  logic        i_sbyte,
    input  logic        i_ubyte,
    input  logic        i_shalf,
    input  logic        i_uhalf,
    output logic        o_data_stall,
    output logic [31:0] o_mem_rd_data,
    output logic        o_mem_fault,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic        i_bus_err,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Counter holds the number of BUSY cycles already completed, so the last allowed
    // cycle is the one where it reads TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             fault_q;
    logic             req;
    logic             accept;
    logic             bus_done;
    logic             timeout;
    logic             fault_now;
    logic             finish;
    logic [3:0]       be_d;
    logic [31:0]      wdata_d;

    assign req       = i_mem_load | i_mem_store;
    assign accept    = (state_q == IDLE) && req && !i_clear_from_writeback;
    assign bus_done  = i_bus_ack | i_bus_err;
    assign timeout   = TIMEOUT_EN && (cnt_q == CNT_LAST);
    // Error beats ack; an ack on the last allowed cycle still completes normally.
    assign fault_now = i_bus_err | (!i_bus_ack & timeout);
    assign finish    = (state_q == BUSY) && !i_clear_from_writeback && (bus_done || timeout);

    always_comb begin
        be_d    = 4'hF;
        wdata_d = i_wr_data;
        if (i_sbyte | i_ubyte) begin
            be_d    = 4'b0001 << i_address[1:0];
            wdata_d = {4{i_wr_data[7:0]}};
        end else if (i_shalf | i_uhalf) begin
            be_d    = 4'b0011 << {i_address[1], 1'b0};
            wdata_d = {2{i_wr_data[15:0]}};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                // A flush cannot retract a live request; only a finished or timed-out one may skip DRAIN.
                if (i_clear_from_writeback) state_d = (bus_done || timeout) ? IDLE : DRAIN;
                else if (bus_done || timeout) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (bus_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_bus_req    = 1'b0;
        o_data_stall = 1'b0;
        o_mem_fault  = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_data_stall = req && !i_clear_from_writeback && !i_reset;
            end
            BUSY: begin
                o_bus_req    = 1'b1;
                o_data_stall = 1'b1;
            end
            DONE: begin
                o_mem_fault = fault_q && !i_clear_from_writeback;
            end
            DRAIN: begin
                o_bus_req    = 1'b1;
                o_data_stall = req;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_bus_we      <= 1'b0;
            o_bus_addr    <= '0;
            o_bus_wdata   <= '0;
            o_bus_be      <= '0;
            o_mem_rd_data <= '0;
            fault_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            if (accept) begin
                o_bus_we    <= i_mem_store;
                o_bus_addr  <= {i_address[31:2], 2'b00};
                o_bus_wdata <= wdata_d;
                o_bus_be    <= be_d;
            end
            if (finish) begin
                fault_q <= fault_now;
                if (fault_now) begin
                    o_mem_rd_data <= '0;
                end else if (!o_bus_we) begin
                    o_mem_rd_data <= i_bus_rdata;
                end
            end
            if ((state_q == BUSY) && (state_d == BUSY)) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule
